fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the system FIFO (the `winc`/`wdata`/`wfull` side of the FIFO memory controller) between `NUM_REQ` requesters such as the ALU result path, register-file readback and the UART-frame builder. The block grants one requester at a time and forwards its data. It allows each requester a bounded burst of up to `MAX_BURST` words, stalls on FIFO full, and then rotates priority so that no requester starves. It sits in the write-clock domain, directly in front of the FIFO.

## Interface
- `NUM_REQ`, default 4: number of requesters, must be ≥ 2.
- `DATA_WIDTH`, default 8: word width; must equal the FIFO data width.
- `MAX_BURST`, default 4: maximum words written per grant, must be ≥ 1.
- `CLK  in  1`: write-domain clock. One clock; all state changes on the rising edge.
- `RST  in  1`: asynchronous, active-low reset.
- `req  in  NUM_REQ`: `req[i]` high means requester i has a word on its data slice.
- `req_data  in  NUM_REQ*DATA_WIDTH`: requester i's word at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `wfull  in  1`: FIFO full flag, write-domain synchronized.
- `winc  out  1`: FIFO write enable.
- `wdata  out  DATA_WIDTH`: FIFO write data.
- `grant  out  NUM_REQ`: one-hot current owner; all zeros when idle.
- `ack  out  NUM_REQ`: one-hot; `ack[i]` high means requester i's word is written at this rising edge.
- `busy  out  1`: high while a requester owns the port.

## Operation
- **State:**
  - `state` ∈ {IDLE, OWN}.
  - `owner`: $clog2(NUM_REQ) bits.
  - `rr_ptr`: $clog2(NUM_REQ) bits; the highest-priority index for the next arbitration.
  - `burst_cnt`: enough bits to count 0..MAX_BURST-1.
- **IDLE:**
  - If `req` ≠ 0, go to OWN at the next edge.
  - The new `owner` is the first set bit found searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `burst_cnt` = 0.
  - If `req` = 0, stay in IDLE.
- **OWN, combinational outputs:**
  - `grant` = one-hot(`owner`).
  - `busy` = 1.
  - `wdata` = `req_data` slice of `owner`.
  - `winc` = `req[owner] & ~wfull`.
  - `ack` = `winc` ? one-hot(`owner`) : 0.
- **OWN, per edge:**
  - If `winc` and `burst_cnt` == MAX_BURST-1: go to IDLE and set `rr_ptr` = (`owner`+1) mod `NUM_REQ`. The burst is complete.
  - Else if `winc`: `burst_cnt` +1 and stay in OWN.
  - Else if `req[owner]` == 0: go to IDLE and set `rr_ptr` = (`owner`+1) mod `NUM_REQ`. This is an early release.
  - Else (`wfull` stall): hold `owner`, `burst_cnt` and `grant`. There is no timeout.
- **IDLE outputs:** `winc` = 0, `wdata` = 0, `grant` = 0, `ack` = 0, `busy` = 0.
- **Requester protocol:**
  - Hold `req` and the data slice stable until `ack`.
  - A new word may be presented in the cycle after `ack`.
  - Drop `req` after the last `ack`.
  - Changing data while `req` is high and no `ack` has occurred is a protocol violation; the result is undefined.
- `wdata` and `winc` are never asserted for a non-owner. At most one `ack` bit is high in any cycle.
- With `MAX_BURST` = 1, the owner is released after every word.
- **Reset (`RST` low, any time, including mid-burst):**
  - `state` = IDLE, `owner` = 0, `rr_ptr` = 0, `burst_cnt` = 0.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - A word in flight without `ack` is not written.

## Timing
- **Arbitration latency:** `req` is sampled high at edge k; `grant` and `busy` are high from cycle k+1. `winc` is high in cycle k+1 if `wfull` = 0.
- **Throughput:** one word per cycle while owned and not full.
- **Turnaround:** exactly one IDLE bubble cycle after every release, before the next grant.
- **Full stall:** `wfull` high gives `winc` = 0 in the same cycle, with no extra latency on resume.
- A worst-case wait for requester i is (NUM_REQ-1)·(MAX_BURST+1) cycles, plus cycles stalled on `wfull`.
- All state is in the `CLK` domain; there are no internal synchronizers.

## Test plan
- **Reset mid-burst:** assert `RST` low during the 2nd word of requester 1 → `grant`, `winc`, `ack` and `busy` go to 0 asynchronously. After release with `req`=0001, `grant`=0001 one cycle later (`rr_ptr` was reset to 0).
- **Single requester, 6 words:** `req`=0010, `wfull`=0 →
  - `grant`=0010 in cycles 1–4 with `winc`/`ack[1]` each cycle (4 words).
  - IDLE in cycle 5.
  - Regrant in cycle 6, with 2 more words in cycles 6–7.
- **All requesting continuously:** `req`=1111 → owners 0,1,2,3,0 in turn, 4 words each, with exactly one idle cycle between grants.
- **Full stall:** `wfull` high for 3 cycles after requester 2's 2nd word →
  - `winc`=0, `ack`=0 and `grant`=0100 held through the stall.
  - The remaining 2 words are written immediately after `wfull` falls.
- **Early release:** requester 2 drops `req` after 2 acks while `req[0]` and `req[3]` are pending → release, then requester 3 is granted (`rr_ptr`=3), followed by requester 0.
- **Data mux:** `req_data` = {8'hD3, 8'hC2, 8'hB1, 8'hA0} (requester 3 down to requester 0), with `req`=1111 → `wdata` sequence A0×4, B1×4, C2×4, D3×4, and `wdata`=0 in bubble cycles.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port among NUM_REQ requesters,
// with bounded bursts, stall on wfull and one idle bubble between grants.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       owner, owner_nxt;
    logic [IW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [BW-1:0]       burst_cnt, burst_cnt_nxt;
    logic [IW-1:0]       pick;
    logic [IW-1:0]       owner_inc;
    logic [NUM_REQ-1:0]  owner_oh;
    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan offsets from farthest to nearest so the nearest set bit above rr_ptr wins.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + 32'(NUM_REQ) - 1 - k) % 32'(NUM_REQ);
            if (req[IW'(idx)]) begin
                pick = IW'(idx);
            end
        end
    end

    assign owner_inc = (owner == LAST_IDX) ? '0 : owner + IW'(1);
    assign owner_oh  = NUM_REQ'(1) << owner;

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        winc          = 1'b0;
        wdata         = '0;
        grant         = '0;
        ack           = '0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                burst_cnt_nxt = '0;
                if (|req) begin
                    state_nxt = OWN;
                    owner_nxt = pick;
                end
            end
            OWN: begin
                grant = owner_oh;
                busy  = 1'b1;
                wdata = slice[owner];
                winc  = req[owner] & ~wfull;
                ack   = winc ? owner_oh : '0;
                if (winc && (burst_cnt == LAST_BEAT)) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner_inc;
                end else if (winc) begin
                    burst_cnt_nxt = burst_cnt + BW'(1);
                end else if (!req[owner]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level requester/arbiter model
// queues expected per-cycle outputs and writes; a negedge monitor pops and compares.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            wfull = 1'b0;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic            busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .wfull(wfull),
        .winc(winc), .wdata(wdata), .grant(grant), .ack(ack), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [N-1:0]  grant;
        logic          busy;
        logic          winc;
        logic [N-1:0]  ack;
        logic [DW-1:0] wdata;
    } exp_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   mon_en = 1'b0;

    // Reference model: who owns the port, words written this grant, next priority start.
    int            m_owner = -1;
    int            m_words = 0;
    int            m_next  = 0;
    int            pkt_left [N];
    logic [DW-1:0] cur_data [N];
    int            new_pkt_pct = 0;
    int            full_pct    = 0;
    bit            fixed_data  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        wr_t  w;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL exp_queue: no expectation queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("grant", 64'(grant), 64'(e.grant));
                chk("busy",  64'(busy),  64'(e.busy));
                chk("winc",  64'(winc),  64'(e.winc));
                chk("ack",   64'(ack),   64'(e.ack));
                chk("wdata", 64'(wdata), 64'(e.wdata));
            end
            if (winc === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL write_queue: unexpected write of %0h at %0t", wdata, $time);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_ack",  64'(ack),   64'(N'(1) << w.idx));
                    chk("write_data", 64'(wdata), 64'(w.data));
                end
            end
        end
    end

    // One cycle: drive requesters and wfull, queue the expected response, advance the model.
    task automatic step();
        logic [N-1:0] rv;
        logic         wf;
        bit           wr;
        int           o;
        for (int i = 0; i < N; i++) begin
            if (pkt_left[i] == 0 && int'($urandom_range(99, 0)) < new_pkt_pct) begin
                pkt_left[i] = int'($urandom_range(7, 1));
                if (!fixed_data) cur_data[i] = DW'($urandom);
            end
        end
        for (int i = 0; i < N; i++) begin
            rv[i] = (pkt_left[i] != 0);
            req_data[i*DW +: DW] = cur_data[i];
        end
        wf    = (int'($urandom_range(99, 0)) < full_pct);
        req   = rv;
        wfull = wf;
        o  = m_owner;
        wr = 1'b0;
        if (o < 0) begin
            exp_q.push_back('{grant: '0, busy: 1'b0, winc: 1'b0, ack: '0, wdata: '0});
            if (rv != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (bit_of(rv, (m_next + k) % N)) m_owner = (m_next + k) % N;
                end
                m_words = 0;
            end
        end else begin
            wr = bit_of(rv, o) && !wf;
            exp_q.push_back('{grant: N'(1) << o, busy: 1'b1, winc: wr,
                              ack: wr ? N'(1) << o : '0, wdata: cur_data[o]});
            if (wr) begin
                wr_q.push_back('{idx: o, data: cur_data[o]});
                m_words++;
                pkt_left[o]--;
                if (!fixed_data) cur_data[o] = DW'($urandom);
                if (m_words == MB) begin
                    m_owner = -1;
                    m_next  = (o + 1) % N;
                end
            end else if (!bit_of(rv, o)) begin
                m_owner = -1;
                m_next  = (o + 1) % N;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_words = 0;
        m_next  = 0;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < N; i++) begin
            pkt_left[i] = 0;
            cur_data[i] = '0;
        end
        req = '1;
        #2;
        chk("reset_grant", 64'(grant), 64'(0));
        chk("reset_busy",  64'(busy),  64'(0));
        chk("reset_winc",  64'(winc),  64'(0));
        repeat (2) @(posedge CLK);
        #1;
        req = '0;
        RST = 1'b1;

        // All four requesting continuously with fixed words A0/B1/C2/D3.
        fixed_data  = 1'b1;
        new_pkt_pct = 0;
        full_pct    = 0;
        for (int i = 0; i < N; i++) begin
            pkt_left[i] = 1000;
            cur_data[i] = DW'(8'hA0 + 8'h11 * i);
        end
        model_reset();
        mon_en = 1'b1;
        repeat (26) step();

        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            if (m_owner == 1 && m_words == 1) found = 1'b1;
            else step();
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL find_burst: requester 1 second word never reached");
        end
        mon_en = 1'b0;
        exp_q.delete();
        wr_q.delete();
        #1;
        chk("pre_reset_grant", 64'(grant), 64'(4'b0010));
        chk("pre_reset_winc",  64'(winc),  64'(1));
        RST = 1'b0;
        #1;
        chk("async_grant", 64'(grant), 64'(0));
        chk("async_winc",  64'(winc),  64'(0));
        chk("async_ack",   64'(ack),   64'(0));
        chk("async_busy",  64'(busy),  64'(0));
        chk("async_wdata", 64'(wdata), 64'(0));
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;

        // After reset rr_ptr is 0, so requester 0 beats requester 1.
        for (int i = 0; i < N; i++) pkt_left[i] = 0;
        pkt_left[0] = 3;
        pkt_left[1] = 2;
        model_reset();
        mon_en = 1'b1;
        step();
        chk("post_reset_grant", 64'(grant), 64'(4'b0001));
        repeat (15) step();

        // Random packets, random wfull stalls, early releases.
        fixed_data  = 1'b0;
        new_pkt_pct = 20;
        full_pct    = 25;
        repeat (3000) step();

        new_pkt_pct = 0;
        full_pct    = 0;
        for (int t = 0; t < 300; t++) begin
            if (m_owner < 0 && pkt_left[0] == 0 && pkt_left[1] == 0 &&
                pkt_left[2] == 0 && pkt_left[3] == 0) break;
            step();
        end
        repeat (3) step();
        mon_en = 1'b0;
        chk("unwritten_words", 64'(wr_q.size()), 64'(0));
        chk("final_idle",      64'(busy),        64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
